// File: rtl/image_bram_pkg.sv
// ============================================================================
// Module      : image_bram_pkg
// Description : Shared FSM state encoding and default geometry for the image
//               BRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package image_bram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 17;
  localparam int DEPTH_DEF  = 76800;

  typedef logic [1:0] state_t;

  localparam state_t ST_COM   = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_PDI   = 2'd2;
  localparam state_t ST_CLEAR = 2'd3;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/image_channel_ram.sv
// ============================================================================
// Module      : image_channel_ram
// Description : One image channel: simple dual-port RAM, registered read-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_channel_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 76800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are intentionally never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      if (32'(raddr_i) < DEPTH) begin
        rdata_q <= mem_q[raddr_i[IDX_W-1:0]];
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/image_bram_arbiter.sv
// ============================================================================
// Module      : image_bram_arbiter
// Description : Arbitrates N_CH image BRAMs between a COM port, a parallel
//               PDI port and a fill engine (IMAGE_BRAM_ARB_CLEAR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_bram_arbiter
  import image_bram_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CLEAR_VAL = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      com_valid,
  output logic                      com_ready,
  input  logic                      com_we,
  input  logic [ch_width(N_CH)-1:0] com_channel,
  input  logic [ADDR_W-1:0]         com_addr,
  input  logic [DATA_W-1:0]         com_wdata,
  output logic [DATA_W-1:0]         com_rdata,
  output logic                      com_rvalid,
  output logic                      com_err,
  input  logic                      pdi_req,
  output logic                      pdi_grant,
  input  logic                      pdi_re,
  input  logic [ADDR_W-1:0]         pdi_addr_read,
  input  logic                      pdi_we,
  input  logic [ADDR_W-1:0]         pdi_addr_write,
  input  logic [N_CH*DATA_W-1:0]    pdi_wdata,
  output logic [N_CH*DATA_W-1:0]    pdi_rdata,
  output logic                      pdi_rvalid,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done
);

  localparam int CH_W = ch_width(N_CH);

  state_t            state_q, state_d;
  logic              com_rvalid_q, com_err_q, pdi_rvalid_q;
  logic [CH_W-1:0]   com_ch_q;

  logic              w_com_acc, w_com_ok, w_com_rd, w_com_wr;
  logic              w_clr;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_re;
  logic [ADDR_W-1:0] w_raddr, w_waddr;
  logic [DATA_W-1:0] w_rd [N_CH];

  assign com_ready = (state_q == ST_COM);
  assign pdi_grant = (state_q == ST_PDI);

  assign w_com_acc = com_valid & com_ready;
  assign w_com_ok  = (32'(com_channel) < N_CH) && (32'(com_addr) < DEPTH);
  assign w_com_rd  = w_com_acc & w_com_ok & ~com_we;
  assign w_com_wr  = w_com_acc & w_com_ok &  com_we;

`ifdef IMAGE_BRAM_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              w_clr_last;

  assign w_clr      = (state_q == ST_CLEAR);
  assign w_clr_addr = clr_cnt_q;
  assign w_clr_last = w_clr && (clr_cnt_q == ADDR_W'(DEPTH - 1));
  assign clear_busy = w_clr;
  assign clear_done = w_clr_last;
`else
  logic w_unused_clear;

  assign w_unused_clear = clear_start;
  assign w_clr          = 1'b0;
  assign w_clr_addr     = '0;
  assign clear_busy     = 1'b0;
  assign clear_done     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
`ifdef IMAGE_BRAM_ARB_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_COM: begin
`ifdef IMAGE_BRAM_ARB_CLEAR_EN
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (pdi_req) begin
          state_d = ST_DRAIN;
        end
`else
        if (pdi_req) begin
          state_d = ST_DRAIN;
        end
`endif
      end
      ST_DRAIN: state_d = ST_PDI;
      ST_PDI: begin
        if (!pdi_req) begin
          state_d = ST_COM;
        end
      end
`ifdef IMAGE_BRAM_ARB_CLEAR_EN
      ST_CLEAR: begin
        if (w_clr_last) begin
          state_d   = ST_COM;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_COM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COM;
      com_rvalid_q <= 1'b0;
      com_err_q    <= 1'b0;
      pdi_rvalid_q <= 1'b0;
      com_ch_q     <= '0;
    end else begin
      state_q      <= state_d;
      com_rvalid_q <= w_com_rd;
      com_err_q    <= w_com_acc & ~w_com_ok;
      pdi_rvalid_q <= pdi_grant & pdi_re;
      if (w_com_rd) begin
        com_ch_q <= com_channel;
      end
    end
  end

`ifdef IMAGE_BRAM_ARB_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

  // Address/enable muxing is shared by all channels; only COM writes are per-channel.
  assign w_re    = pdi_grant ? pdi_re : w_com_rd;
  assign w_raddr = pdi_grant ? pdi_addr_read : com_addr;
  assign w_waddr = w_clr ? w_clr_addr : (pdi_grant ? pdi_addr_write : com_addr);

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic              w_we;
      logic [DATA_W-1:0] w_wdata;

      assign w_we    = w_clr | (pdi_grant & pdi_we) | (w_com_wr & (32'(com_channel) == k));
      assign w_wdata = w_clr     ? DATA_W'(CLEAR_VAL) :
                       pdi_grant ? pdi_wdata[k*DATA_W +: DATA_W] : com_wdata;

      image_channel_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .re_i    (w_re),
        .raddr_i (w_raddr),
        .rdata_o (w_rd[k])
      );

      assign pdi_rdata[k*DATA_W +: DATA_W] = w_rd[k];
    end
  endgenerate

  assign com_rdata  = w_rd[com_ch_q];
  assign com_rvalid = com_rvalid_q;
  assign com_err    = com_err_q;
  assign pdi_rvalid = pdi_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_image_bram_arbiter.sv
// ============================================================================
// Module      : tb_image_bram_arbiter
// Description : Scoreboard bench for image_bram_arbiter (clear checks active
//               when IMAGE_BRAM_ARB_CLEAR_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_image_bram_arbiter;

  localparam int N_CH   = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;
  localparam int CH_W   = 2;
  localparam int PW     = N_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              com_valid = 1'b0, com_we = 1'b0;
  logic [CH_W-1:0]   com_channel = '0;
  logic [ADDR_W-1:0] com_addr = '0;
  logic [DATA_W-1:0] com_wdata = '0;
  logic              com_ready, com_rvalid, com_err;
  logic [DATA_W-1:0] com_rdata;
  logic              pdi_req = 1'b0, pdi_re = 1'b0, pdi_we = 1'b0;
  logic [ADDR_W-1:0] pdi_addr_read = '0, pdi_addr_write = '0;
  logic [PW-1:0]     pdi_wdata = '0;
  logic              pdi_grant, pdi_rvalid;
  logic [PW-1:0]     pdi_rdata;
  logic              clear_start = 1'b0;
  logic              clear_busy, clear_done;

  image_bram_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VAL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .com_valid(com_valid), .com_ready(com_ready), .com_we(com_we),
    .com_channel(com_channel), .com_addr(com_addr), .com_wdata(com_wdata),
    .com_rdata(com_rdata), .com_rvalid(com_rvalid), .com_err(com_err),
    .pdi_req(pdi_req), .pdi_grant(pdi_grant), .pdi_re(pdi_re),
    .pdi_addr_read(pdi_addr_read), .pdi_we(pdi_we), .pdi_addr_write(pdi_addr_write),
    .pdi_wdata(pdi_wdata), .pdi_rdata(pdi_rdata), .pdi_rvalid(pdi_rvalid),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] data;
    int            due;
  } exp_t;

  exp_t com_q[$];
  exp_t pdi_q[$];
  int   err_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (com_q.size() > 0 && com_q[0].due < cyc) begin
        e = com_q.pop_front();
        chk("com_rvalid_missing", 32'(com_rvalid), 32'd1);
      end
      if (com_rvalid) begin
        if (com_q.size() == 0) chk("com_rvalid_unexpected", 32'(com_rvalid), 32'd0);
        else begin
          e = com_q.pop_front();
          chk("com_rdata", 32'(com_rdata), 32'(e.data[DATA_W-1:0]));
          chk("com_rvalid_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (pdi_q.size() > 0 && pdi_q[0].due < cyc) begin
        e = pdi_q.pop_front();
        chk("pdi_rvalid_missing", 32'(pdi_rvalid), 32'd1);
      end
      if (pdi_rvalid) begin
        if (pdi_q.size() == 0) chk("pdi_rvalid_unexpected", 32'(pdi_rvalid), 32'd0);
        else begin
          e = pdi_q.pop_front();
          chk("pdi_rdata", 32'(pdi_rdata), 32'(e.data));
          chk("pdi_rvalid_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (err_q.size() > 0 && err_q[0] < cyc) begin
        void'(err_q.pop_front());
        chk("com_err_missing", 32'(com_err), 32'd1);
      end
      if (com_err) begin
        if (err_q.size() == 0) chk("com_err_unexpected", 32'(com_err), 32'd0);
        else chk("com_err_timing", 32'(cyc), 32'(err_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic com_wr(input int ch, input int addr, input logic [7:0] wd, input logic bad);
    com_valid = 1'b1; com_we = 1'b1; com_wdata = wd;
    com_channel = CH_W'(ch); com_addr = ADDR_W'(addr);
    if (bad) err_q.push_back(cyc + 1);
    tick();
    com_valid = 1'b0;
  endtask

  task automatic com_rd(input int ch, input int addr, input logic [7:0] exp, input logic bad);
    exp_t e;
    com_valid = 1'b1; com_we = 1'b0;
    com_channel = CH_W'(ch); com_addr = ADDR_W'(addr);
    if (bad) err_q.push_back(cyc + 1);
    else begin
      e.data = PW'(exp); e.due = cyc + 1;
      com_q.push_back(e);
    end
    tick();
    com_valid = 1'b0;
  endtask

  task automatic pdi_op(input logic re, input int ra, input logic we, input int wa,
                        input logic [PW-1:0] wd, input logic [PW-1:0] exp);
    exp_t e;
    pdi_re = re; pdi_addr_read = ADDR_W'(ra);
    pdi_we = we; pdi_addr_write = ADDR_W'(wa); pdi_wdata = wd;
    if (re) begin
      e.data = exp; e.due = cyc + 1;
      pdi_q.push_back(e);
    end
    tick();
    pdi_re = 1'b0; pdi_we = 1'b0;
  endtask

  task automatic enter_pdi();
    int n = 0;
    pdi_req = 1'b1;
    while (!pdi_grant && n < 10) begin
      tick();
      n++;
    end
    chk("pdi_grant_wait", 32'(pdi_grant), 32'd1);
  endtask

  task automatic leave_pdi();
    pdi_req = 1'b0;
    tick();
    chk("pdi_grant_drop", 32'(pdi_grant), 32'd0);
  endtask

`ifdef IMAGE_BRAM_ARB_CLEAR_EN
  function automatic logic [PW-1:0] fill_pat(input int a);
    logic [7:0] b;
    b = 8'h80 + 8'(a);
    return {b, b, b};
  endfunction
`endif

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_com_ready", 32'(com_ready), 32'd1);
    chk("rst_pdi_grant", 32'(pdi_grant), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_com_rvalid", 32'(com_rvalid), 32'd0);
    chk("rst_com_err", 32'(com_err), 32'd0);
    chk("rst_pdi_rvalid", 32'(pdi_rvalid), 32'd0);
    chk("rst_pdi_rdata", 32'(pdi_rdata), 32'd0);

    // COM write/read isolation
    com_wr(0, 5, 8'h50, 1'b0);
    com_wr(1, 5, 8'h51, 1'b0);
    com_wr(2, 5, 8'hA5, 1'b0);
    com_rd(2, 5, 8'hA5, 1'b0);
    com_rd(0, 5, 8'h50, 1'b0);
    com_rd(1, 5, 8'h51, 1'b0);

    // Out-of-range channel and address
    com_wr(3, 5, 8'hEE, 1'b1);
    com_wr(0, DEPTH, 8'hEE, 1'b1);
    com_rd(3, 5, 8'h00, 1'b1);
    com_rd(0, 5, 8'h50, 1'b0);
    com_rd(1, 5, 8'h51, 1'b0);
    com_rd(2, 5, 8'hA5, 1'b0);

    // pdi_req alongside a COM read: read completes in DRAIN
    pdi_req = 1'b1;
    com_rd(2, 5, 8'hA5, 1'b0);
    chk("drain_com_ready", 32'(com_ready), 32'd0);
    chk("drain_pdi_grant", 32'(pdi_grant), 32'd0);
    tick();
    chk("pdi_grant_after_drain", 32'(pdi_grant), 32'd1);

    // COM is blocked during PDI
    com_valid = 1'b1; com_we = 1'b1; com_channel = 2'd0; com_addr = 8'd5; com_wdata = 8'hEE;
    chk("pdi_com_ready", 32'(com_ready), 32'd0);
    tick();
    com_valid = 1'b0;

    // Read-first on same address
    pdi_op(1'b0, 0, 1'b1, 10, 24'h111111, '0);
    pdi_op(1'b1, 10, 1'b1, 10, {8'h33, 8'h22, 8'h44}, 24'h111111);
    pdi_op(1'b1, 10, 1'b0, 0, '0, {8'h33, 8'h22, 8'h44});
    chk("pdi_grant_held", 32'(pdi_grant), 32'd1);
    leave_pdi();
    chk("com_ready_after_pdi", 32'(com_ready), 32'd1);

    // PDI strobes without grant are ignored
    pdi_re = 1'b1; pdi_addr_read = 8'd10;
    pdi_we = 1'b1; pdi_addr_write = 8'd10; pdi_wdata = 24'hFFFFFF;
    tick();
    pdi_re = 1'b0; pdi_we = 1'b0;
    com_rd(0, 5, 8'h50, 1'b0);
    com_rd(0, 10, 8'h44, 1'b0);
    com_rd(1, 10, 8'h22, 1'b0);
    com_rd(2, 10, 8'h33, 1'b0);

`ifdef IMAGE_BRAM_ARB_CLEAR_EN
    begin
      int busy_n, done_n, done_at, bound;
      enter_pdi();
      for (int a = 0; a < DEPTH; a++) pdi_op(1'b0, 0, 1'b1, a, fill_pat(a), '0);
      leave_pdi();

      // Abort a clear by reset while the counter is at 7
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      busy_n = 0; done_n = 0; bound = 0;
      while (busy_n < 8 && bound < 40) begin
        @(negedge clk);
        bound++;
        if (clear_busy) busy_n++;
        if (clear_done) done_n++;
      end
      rst_n = 1'b0;
      chk("abort_busy_cycles", 32'(busy_n), 32'd8);
      chk("abort_no_done", 32'(done_n), 32'd0);
      #1;
      chk("abort_busy_low", 32'(clear_busy), 32'd0);
      chk("abort_done_low", 32'(clear_done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("abort_com_ready", 32'(com_ready), 32'd1);
      enter_pdi();
      for (int a = 0; a < DEPTH; a++) pdi_op(1'b1, a, 1'b0, 0, '0, (a < 7) ? '0 : fill_pat(a));
      leave_pdi();

      // clear_start and pdi_req together: clear wins, PDI served afterwards
      clear_start = 1'b1; pdi_req = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("clear_first_busy", 32'(clear_busy), 32'd1);
      chk("clear_first_no_grant", 32'(pdi_grant), 32'd0);
      busy_n = 0; done_n = 0; done_at = -1; bound = 0;
      @(negedge clk);
      while (clear_busy && bound < 60) begin
        busy_n++;
        if (clear_done) begin
          done_n++;
          done_at = busy_n;
        end
        @(negedge clk);
        bound++;
      end
      if (clear_done) done_n++;
      chk("clear_busy_cycles", 32'(busy_n), 32'(DEPTH));
      chk("clear_done_pulses", 32'(done_n), 32'd1);
      chk("clear_done_position", 32'(done_at), 32'(DEPTH));
      tick();
      enter_pdi();
      for (int a = 0; a < DEPTH; a++) pdi_op(1'b1, a, 1'b0, 0, '0, '0);
      leave_pdi();
      com_rd(2, 5, 8'h00, 1'b0);
    end
`else
    // Clear engine disabled: clear_start has no effect
    clear_start = 1'b1;
    tick();
    chk("noclr_busy", 32'(clear_busy), 32'd0);
    chk("noclr_com_ready", 32'(com_ready), 32'd1);
    tick();
    chk("noclr_done", 32'(clear_done), 32'd0);
    clear_start = 1'b0;
    com_rd(2, 5, 8'hA5, 1'b0);
`endif

    repeat (4) tick();
    chk("com_queue_empty", 32'(com_q.size()), 32'd0);
    chk("pdi_queue_empty", 32'(pdi_q.size()), 32'd0);
    chk("err_queue_empty", 32'(err_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/image_bram_arbiter.md
IMAGE_BRAM_ARBITER -- requirements
Module: image_bram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- N_CH, 3, number of image channels, 1..8
- DATA_W, 8, bits per pixel sample
- ADDR_W, 17, address width
- DEPTH, 76800, words per channel, ≤ 2**ADDR_W
- CLEAR_VAL, 0, fill value used by the clear engine
REQ-002 Ports SHALL be, one per line:
- clk  in  1  main clock
- rst_n  in  1  reset
- com_valid  in  1  COM request valid
- com_ready  out  1  COM request accepted this cycle when high with com_valid
- com_we  in  1  1 = write, 0 = read
- com_channel  in  CH_W  0-based channel index; CH_W = max(1, clog2(N_CH))
- com_addr  in  ADDR_W  COM address
- com_wdata  in  DATA_W  COM write data
- com_rdata  out  DATA_W  COM read data
- com_rvalid  out  1  com_rdata valid pulse
- com_err  out  1  pulse on out-of-range channel or address
- pdi_req  in  1  request parallel mode
- pdi_grant  out  1  parallel mode active
- pdi_re  in  1  read strobe, all channels
- pdi_addr_read  in  ADDR_W  PDI read address
- pdi_we  in  1  write strobe, all channels
- pdi_addr_write  in  ADDR_W  PDI write address
- pdi_wdata  in  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- pdi_rdata  out  N_CH*DATA_W  same packing
- pdi_rvalid  out  1  pdi_rdata valid pulse
- clear_start  in  1  start fill of all channels
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse at clear completion
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be COM, DRAIN, PDI, CLEAR; reset state COM.
REQ-005 COM: com_ready=1; clear_start -> CLEAR (clear_start wins over pdi_req); else pdi_req -> DRAIN.
REQ-006 DRAIN: exactly one cycle, com_ready=0, pending COM read completes; -> PDI.
REQ-007 PDI: pdi_grant=1, com_ready=0; pdi_req low -> COM next cycle, pdi_grant low in that cycle.
REQ-008 A COM transfer SHALL occur only on com_valid&com_ready, touching only channel com_channel.
REQ-009 COM read latency SHALL be 1: com_rdata/com_rvalid registered, com_rvalid high exactly one cycle after acceptance.
REQ-010 com_channel ≥ N_CH or com_addr ≥ DEPTH SHALL drop the access (no write, no com_rvalid) and pulse com_err the next cycle.
REQ-011 PDI read and write SHALL proceed in the same cycle on all channels; pdi_rvalid one cycle after pdi_re; strobes ignored unless pdi_grant=1.
REQ-012 Same-address PDI read and write in one cycle SHALL return the old data (read-first).
REQ-013 CLEAR: clear_busy=1, address counter 0..DEPTH-1, one word per cycle to all channels with CLEAR_VAL; after DEPTH-1 -> COM with clear_done pulsed in that transition cycle; clear takes exactly DEPTH cycles.
REQ-014 clear_start and pdi_req SHALL be ignored outside COM; pdi_req held during CLEAR is served after return to COM.

Reset
REQ-015 On rst_n low: state COM, com_ready=1 (after release), all other outputs 0, counter 0; memory contents SHALL NOT be reset.
REQ-016 Reset during CLEAR SHALL abort it without clear_done; partially cleared memory remains.

Configuration
REQ-017 Macro IMAGE_BRAM_ARB_CLEAR_EN: defined -> CLEAR state and clear ports functional; undefined -> no CLEAR state/counter, clear_start ignored, clear_busy and clear_done tied 0, ports retained.

Structure
REQ-018 Package image_bram_pkg SHALL hold the FSM state typedef and default DATA_W/ADDR_W/DEPTH constants.
REQ-019 Storage SHALL be N_CH instances of sub-module image_channel_ram (simple dual-port, registered read, read-first).

Verification
REQ-020 Bench SHALL cover:
- COM write ch2 addr 5 = 0xA5, then read -> com_rdata 0xA5, com_rvalid one cycle after accept, ch0/ch1 addr 5 unchanged.
- com_channel=3 (N_CH=3) write -> com_err pulse, no memory change, no com_rvalid.
- pdi_req during pending COM read -> COM read returns in DRAIN, pdi_grant high the following cycle.
- PDI read/write same addr 10 (old 0x11, new {0x33,0x22,0x44}) -> pdi_rdata old, next read new.
- clear_start with DEPTH=16 -> clear_busy 16 cycles, clear_done one pulse, all words 0; clear_start and pdi_req together -> CLEAR first.
- rst_n low at clear counter 7 -> no clear_done, addresses ≥7 retain old data.
